// File: rtl/pipeline2d_unpack.sv
// Unpacks one NUM_ELEMS-wide vector beat into a scalar element stream, index 0 first,
// flagging the final element so the next beat can follow with no bubble.
module pipeline2d_unpack #(
  parameter int unsigned ELEM_WIDTH = 32,
  parameter int unsigned NUM_ELEMS  = 32,
  parameter int unsigned CNT_WIDTH  = $clog2(NUM_ELEMS + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_ELEMS-1:0][ELEM_WIDTH-1:0] data_in,
  input  logic [CNT_WIDTH-1:0]                 data_in_cnt,
  input  logic                                 data_in_val,
  output logic                                 data_in_rdy,
  output logic [ELEM_WIDTH-1:0]                elem_out,
  output logic [CNT_WIDTH-1:0]                 elem_out_idx,
  output logic                                 elem_out_last,
  output logic                                 elem_out_val,
  input  logic                                 elem_out_rdy,
  output logic                                 busy
);

  localparam int unsigned IDX_W = $clog2(NUM_ELEMS);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e                               state_q, state_d;
  logic [CNT_WIDTH-1:0]                 idx_q, idx_d;
  logic [CNT_WIDTH-1:0]                 cnt_q, cnt_d;
  logic [NUM_ELEMS-1:0][ELEM_WIDTH-1:0] hold_q;

  logic                 active_c;
  logic                 last_c;
  logic                 xfer_c;
  logic                 accept_c;
  logic                 load_c;
  logic [CNT_WIDTH-1:0] sat_cnt_c;

  // Handshake terms; input ready depends only on held state and the consumer's ready
  assign active_c  = (state_q == DRAIN);
  assign last_c    = (idx_q == cnt_q - CNT_WIDTH'(1));
  assign xfer_c    = active_c & elem_out_rdy;
  assign accept_c  = data_in_val & data_in_rdy;
  assign load_c    = accept_c & (data_in_cnt != '0);
  assign sat_cnt_c = (data_in_cnt > CNT_WIDTH'(NUM_ELEMS)) ? CNT_WIDTH'(NUM_ELEMS) : data_in_cnt;

  assign data_in_rdy   = ~active_c | (elem_out_rdy & last_c);
  assign elem_out      = hold_q[IDX_W'(idx_q)];
  assign elem_out_idx  = idx_q;
  assign elem_out_last = active_c & last_c;
  assign elem_out_val  = active_c;
  assign busy          = active_c;

  // State register and beat buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      if (load_c) begin
        hold_q <= data_in;
      end
    end
  end

  // Next-state: zero-count beats are swallowed without leaving or entering DRAIN
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (load_c) begin
          state_d = DRAIN;
          idx_d   = '0;
          cnt_d   = sat_cnt_c;
        end
      end
      DRAIN: begin
        if (xfer_c) begin
          if (!last_c) begin
            idx_d = idx_q + CNT_WIDTH'(1);
          end else if (load_c) begin
            idx_d = '0;
            cnt_d = sat_cnt_c;
          end else begin
            state_d = IDLE;
            idx_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pipeline2d_unpack.sv
// Bench for pipeline2d_unpack: directed scenarios plus a queue scoreboard fed on beat acceptance.
module tb_pipeline2d_unpack;

  localparam int unsigned EW = 8;
  localparam int unsigned NE = 4;
  localparam int unsigned CW = $clog2(NE + 1);

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NE-1:0][EW-1:0] data_in;
  logic [CW-1:0]        data_in_cnt;
  logic                 data_in_val;
  logic                 data_in_rdy;
  logic [EW-1:0]        elem_out;
  logic [CW-1:0]        elem_out_idx;
  logic                 elem_out_last;
  logic                 elem_out_val;
  logic                 elem_out_rdy;
  logic                 busy;

  typedef struct packed {
    logic [EW-1:0] d;
    logic [CW-1:0] i;
    logic          l;
  } item_t;

  item_t sb_q[$];
  int    sb_total = 0;
  int    sb_pass  = 0;
  int    n_total  = 0;
  int    n_pass   = 0;
  logic  prev_stall = 1'b0;
  item_t prev_item;

  always #5 clk = ~clk;

  pipeline2d_unpack #(.ELEM_WIDTH(EW), .NUM_ELEMS(NE)) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .data_in_cnt   (data_in_cnt),
    .data_in_val   (data_in_val),
    .data_in_rdy   (data_in_rdy),
    .elem_out      (elem_out),
    .elem_out_idx  (elem_out_idx),
    .elem_out_last (elem_out_last),
    .elem_out_val  (elem_out_val),
    .elem_out_rdy  (elem_out_rdy),
    .busy          (busy)
  );

  // Scoreboard: pop on element handshake, push on beat acceptance, check hold during stall
  always @(negedge clk) begin
    item_t got;
    item_t exp;
    item_t it;
    int    n;
    got.d = elem_out;
    got.i = elem_out_idx;
    got.l = elem_out_last;
    if (rst) begin
      sb_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        sb_total++;
        if (!(elem_out_val === 1'b1 && got === prev_item))
          $display("FAIL stall_hold: got val=%b %h expected val=1 %h", elem_out_val, got, prev_item);
        else
          sb_pass++;
      end
      if (elem_out_val && elem_out_rdy) begin
        sb_total++;
        if (sb_q.size() == 0) begin
          $display("FAIL sb_extra_elem: got %h expected no element", got);
        end else begin
          exp = sb_q.pop_front();
          if (got !== exp)
            $display("FAIL sb_elem: got d=%h i=%0d l=%b expected d=%h i=%0d l=%b",
                     got.d, got.i, got.l, exp.d, exp.i, exp.l);
          else
            sb_pass++;
        end
      end
      if (data_in_val && data_in_rdy && data_in_cnt != '0) begin
        n = (int'(data_in_cnt) > int'(NE)) ? int'(NE) : int'(data_in_cnt);
        for (int k = 0; k < n; k++) begin
          it.d = data_in[k];
          it.i = CW'(k);
          it.l = (k == n - 1);
          sb_q.push_back(it);
        end
      end
      prev_stall = elem_out_val && !elem_out_rdy;
      prev_item  = got;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    data_in = '0; data_in_cnt = '0; data_in_val = 1'b0; elem_out_rdy = 1'b1;
    tick(); tick();
    @(negedge clk);
    n_total++;
    if ({elem_out_val, elem_out, elem_out_idx, elem_out_last, busy, data_in_rdy} !== {1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_state: got val=%b d=%h i=%0d l=%b busy=%b rdy=%b expected 0 00 0 0 0 1",
               elem_out_val, elem_out, elem_out_idx, elem_out_last, busy, data_in_rdy);
    else n_pass++;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single_beat();
    logic [EW-1:0] e;
    tick();
    data_in = 32'h44332211; data_in_cnt = 3'd4; data_in_val = 1'b1; elem_out_rdy = 1'b1;
    @(negedge clk);
    n_total++;
    if (data_in_rdy !== 1'b1) $display("FAIL single_idle_rdy: got %b expected 1", data_in_rdy);
    else n_pass++;
    tick();
    data_in_val = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e = 8'(8'h11 * (i + 1));
      @(negedge clk);
      n_total++;
      if ({elem_out_val, elem_out, elem_out_idx, elem_out_last, data_in_rdy} !== {1'b1, e, 3'(i), (i == 3), (i == 3)})
        $display("FAIL single_elem%0d: got val=%b d=%h i=%0d l=%b rdy=%b expected 1 %h %0d %b %b",
                 i, elem_out_val, elem_out, elem_out_idx, elem_out_last, data_in_rdy, e, i, (i == 3), (i == 3));
      else n_pass++;
      tick();
    end
    @(negedge clk);
    n_total++;
    if ({elem_out_val, busy} !== 2'b00) $display("FAIL single_done: got val=%b busy=%b expected 0 0", elem_out_val, busy);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [EW-1:0] exp_d [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hB1, 8'hB2};
    logic          exp_l [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic          acc;
    int            nacc = 0;
    tick();
    data_in = 32'h44332211; data_in_cnt = 3'd4; data_in_val = 1'b1; elem_out_rdy = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      acc = data_in_val & data_in_rdy;
      if (i > 0) begin
        n_total++;
        if ({elem_out_val, elem_out, elem_out_last} !== {1'b1, exp_d[i-1], exp_l[i-1]})
          $display("FAIL b2b_elem%0d: got val=%b d=%h l=%b expected 1 %h %b",
                   i - 1, elem_out_val, elem_out, elem_out_last, exp_d[i-1], exp_l[i-1]);
        else n_pass++;
      end
      tick();
      if (acc) begin
        nacc++;
        if (nacc == 1) begin data_in = 32'h0000B2B1; data_in_cnt = 3'd2; end
        else data_in_val = 1'b0;
      end
    end
    @(negedge clk);
    n_total++;
    if (elem_out_val !== 1'b0) $display("FAIL b2b_done: got val=%b expected 0", elem_out_val);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    tick();
    data_in = 32'h44332211; data_in_cnt = 3'd4; data_in_val = 1'b1; elem_out_rdy = 1'b1;
    @(negedge clk);
    tick();
    data_in = 32'h00000099; data_in_cnt = 3'd1;
    @(negedge clk);
    tick();
    elem_out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if ({elem_out_val, elem_out, elem_out_idx, elem_out_last, data_in_rdy} !== {1'b1, 8'h22, 3'd1, 1'b0, 1'b0})
        $display("FAIL bp_stall%0d: got val=%b d=%h i=%0d l=%b rdy=%b expected 1 22 1 0 0",
                 i, elem_out_val, elem_out, elem_out_idx, elem_out_last, data_in_rdy);
      else n_pass++;
      tick();
    end
    elem_out_rdy = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    n_total++;
    if ({elem_out, elem_out_idx} !== {8'h33, 3'd2}) $display("FAIL bp_resume: got %h/%0d expected 33/2", elem_out, elem_out_idx);
    else n_pass++;
    tick();
    @(negedge clk);
    n_total++;
    if ({elem_out, elem_out_last, data_in_rdy} !== {8'h44, 1'b1, 1'b1})
      $display("FAIL bp_last: got d=%h l=%b rdy=%b expected 44 1 1", elem_out, elem_out_last, data_in_rdy);
    else n_pass++;
    tick();
    data_in_val = 1'b0;
    @(negedge clk);
    n_total++;
    if ({elem_out_val, elem_out, elem_out_idx, elem_out_last} !== {1'b1, 8'h99, 3'd0, 1'b1})
      $display("FAIL bp_next_beat: got val=%b d=%h i=%0d l=%b expected 1 99 0 1",
               elem_out_val, elem_out, elem_out_idx, elem_out_last);
    else n_pass++;
    tick();
  endtask

  task automatic test_counts();
    int nout = 0;
    int last_pos = 0;
    tick();
    data_in = 32'h0000005A; data_in_cnt = 3'd1; data_in_val = 1'b1; elem_out_rdy = 1'b1;
    @(negedge clk);
    tick();
    data_in_val = 1'b0;
    @(negedge clk);
    n_total++;
    if ({elem_out_val, elem_out, elem_out_idx, elem_out_last} !== {1'b1, 8'h5A, 3'd0, 1'b1})
      $display("FAIL cnt1_elem: got val=%b d=%h i=%0d l=%b expected 1 5a 0 1",
               elem_out_val, elem_out, elem_out_idx, elem_out_last);
    else n_pass++;
    tick();
    data_in = 32'hFFFFFFFF; data_in_cnt = 3'd0; data_in_val = 1'b1;
    @(negedge clk);
    n_total++;
    if (data_in_rdy !== 1'b1) $display("FAIL cnt0_rdy: got %b expected 1", data_in_rdy);
    else n_pass++;
    tick();
    data_in_val = 1'b0;
    @(negedge clk);
    n_total++;
    if ({elem_out_val, busy, data_in_rdy} !== 3'b001)
      $display("FAIL cnt0_no_output: got val=%b busy=%b rdy=%b expected 0 0 1", elem_out_val, busy, data_in_rdy);
    else n_pass++;
    tick();
    data_in = 32'hD4D3D2D1; data_in_cnt = 3'd7; data_in_val = 1'b1;
    @(negedge clk);
    tick();
    data_in_val = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (elem_out_val) begin
        nout++;
        if (elem_out_last) last_pos = nout;
      end
      tick();
    end
    n_total++;
    if (nout != 4 || last_pos != 4) $display("FAIL cnt7_saturate: got %0d elems last at %0d expected 4 last at 4", nout, last_pos);
    else n_pass++;
  endtask

  task automatic test_reset_mid_drain();
    tick();
    data_in = 32'h44332211; data_in_cnt = 3'd4; data_in_val = 1'b1; elem_out_rdy = 1'b1;
    @(negedge clk);
    tick();
    data_in_val = 1'b0;
    @(negedge clk); tick();
    @(negedge clk); tick();
    @(negedge clk);
    n_total++;
    if (elem_out_idx !== 3'd2) $display("FAIL rmd_pre_idx: got %0d expected 2", elem_out_idx);
    else n_pass++;
    #1 rst = 1'b1;
    tick();
    @(negedge clk);
    n_total++;
    if ({elem_out_val, busy, data_in_rdy, elem_out} !== {1'b0, 1'b0, 1'b1, 8'h00})
      $display("FAIL rmd_flush: got val=%b busy=%b rdy=%b d=%h expected 0 0 1 00", elem_out_val, busy, data_in_rdy, elem_out);
    else n_pass++;
    tick();
    rst = 1'b0;
    data_in = 32'h0000C2C1; data_in_cnt = 3'd2; data_in_val = 1'b1;
    @(negedge clk);
    tick();
    data_in_val = 1'b0;
    @(negedge clk);
    n_total++;
    if ({elem_out_val, elem_out, elem_out_idx} !== {1'b1, 8'hC1, 3'd0})
      $display("FAIL rmd_restart: got val=%b d=%h i=%0d expected 1 c1 0", elem_out_val, elem_out, elem_out_idx);
    else n_pass++;
    tick();
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 10000; c++) begin
      tick();
      data_in      = 32'($urandom);
      data_in_cnt  = 3'($urandom_range(0, 7));
      data_in_val  = ($urandom_range(0, 1) == 1);
      elem_out_rdy = ($urandom_range(0, 9) < 7);
    end
    tick();
    data_in_val = 1'b0; elem_out_rdy = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    @(negedge clk);
    n_total++;
    if (sb_q.size() != 0 || elem_out_val !== 1'b0)
      $display("FAIL rand_drained: got %0d pending val=%b expected 0 pending val=0", sb_q.size(), elem_out_val);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_backpressure();
    test_counts();
    test_reset_mid_drain();
    test_random();
    tick();
    n_total += sb_total;
    n_pass  += sb_pass;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
